// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer, strobe and flag control for the asynchronous FIFO.
// Define FIFO_WR_SYNC3_EN to use a three-flop read-pointer synchronizer instead of two.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_inc,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full means the write pointer equals the read pointer with its two Gray MSBs inverted.
  localparam logic [ADDR_WIDTH:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] r_sync1;
`ifdef FIFO_WR_SYNC3_EN
  logic [ADDR_WIDTH:0] r_sync2;
`endif
  logic [ADDR_WIDTH:0] r_rdptr_sync;
  logic [ADDR_WIDTH:0] r_wr_bin;

  logic [ADDR_WIDTH:0] w_wr_bin_next;
  logic [ADDR_WIDTH:0] w_wr_gray_next;
  logic [ADDR_WIDTH:0] w_rd_bin_sync;
  logic [ADDR_WIDTH:0] w_level_next;
  logic                w_ovf_set;

  assign wr_inc         = wr_en & ~wr_full;
  assign wr_addr        = r_wr_bin[ADDR_WIDTH-1:0];
  assign w_wr_bin_next  = r_wr_bin + PW'(wr_inc);
  assign w_wr_gray_next = w_wr_bin_next ^ (w_wr_bin_next >> 1);
  assign w_level_next   = w_wr_bin_next - w_rd_bin_sync;
  assign w_ovf_set      = wr_en & wr_full;

  always_comb begin
    w_rd_bin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      w_rd_bin_sync[i] = ^(r_rdptr_sync >> i);
    end
  end

  // Only the raw Gray value crosses into wr_clk; nothing sits between the stages.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_sync1      <= '0;
`ifdef FIFO_WR_SYNC3_EN
      r_sync2      <= '0;
`endif
      r_rdptr_sync <= '0;
    end else begin
      r_sync1      <= rd_ptr_gray;
`ifdef FIFO_WR_SYNC3_EN
      r_sync2      <= r_sync1;
      r_rdptr_sync <= r_sync2;
`else
      r_rdptr_sync <= r_sync1;
`endif
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_wr_bin       <= '0;
      wr_ptr_gray    <= '0;
      wr_full        <= 1'b0;
      wr_almost_full <= 1'b0;
      wr_level       <= '0;
      wr_overflow    <= 1'b0;
    end else begin
      r_wr_bin       <= w_wr_bin_next;
      wr_ptr_gray    <= w_wr_gray_next;
      wr_full        <= (w_wr_gray_next == (r_rdptr_sync ^ FULL_MASK));
      wr_almost_full <= (w_level_next >= AFULL_LVL);
      wr_level       <= w_level_next;
      if (w_ovf_set) begin
        wr_overflow <= 1'b1;
      end else if (ovf_clr) begin
        wr_overflow <= 1'b0;
      end
    end
  end

endmodule
